// File: rtl/keccak_chi_compress.sv
// Share compression and flow-control stage behind the masked Keccak chi S-box.
// Optional build macro KECCAK_CHI_IOTA_EN folds the iota round constant into lane a, share 0, row 0.
module keccak_chi_compress #(
  parameter int d          = 2,
  parameter int FIFO_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 rc_i,
  input  logic [(d+1)**2-1:0]  ap_i,
  input  logic [(d+1)**2-1:0]  bp_i,
  input  logic [(d+1)**2-1:0]  cp_i,
  input  logic [(d+1)**2-1:0]  dp_i,
  input  logic [(d+1)**2-1:0]  ep_i,
  output logic [d:0]           a_o,
  output logic [d:0]           b_o,
  output logic [d:0]           c_o,
  output logic [d:0]           d_o,
  output logic [d:0]           e_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic                 out_last_o,
  output logic [2:0]           row_o
);

  localparam int W_IN  = (d+1)**2;
  localparam int W_OUT = d+1;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH+1);

  typedef struct packed {
    logic [2:0]       row;
    logic [W_OUT-1:0] a;
    logic [W_OUT-1:0] b;
    logic [W_OUT-1:0] c;
    logic [W_OUT-1:0] d;
    logic [W_OUT-1:0] e;
  } entry_t;

  function automatic logic [W_OUT-1:0] compress(input logic [W_IN-1:0] x);
    logic [W_OUT-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < W_OUT; i++)
      for (int unsigned j = 0; j < W_OUT; j++)
        r[i] = r[i] ^ x[i*W_OUT + j];
    return r;
  endfunction

  logic          s1_valid;
  logic [2:0]    s1_row;
  logic          s1_rc;
  logic [2:0]    row_cnt;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  entry_t        mem [FIFO_DEPTH];
  entry_t        s1_entry;
  entry_t        head;
  logic          accept;
  logic          push;
  logic          pop;

  // Ready looks only at registered state: the S-box result arrives a cycle
  // after acceptance and cannot be stalled, so room is reserved up front.
  assign in_ready_o  = (int'(count) + int'(s1_valid)) < FIFO_DEPTH;
  assign out_valid_o = (count != '0);
  assign accept      = in_valid_i && in_ready_o && !clr_i;
  assign push        = s1_valid && !clr_i;
  assign pop         = out_valid_o && out_ready_i && !clr_i;

  always_comb begin
    s1_entry     = '0;
    s1_entry.row = s1_row;
    s1_entry.a   = compress(ap_i);
    s1_entry.b   = compress(bp_i);
    s1_entry.c   = compress(cp_i);
    s1_entry.d   = compress(dp_i);
    s1_entry.e   = compress(ep_i);
`ifdef KECCAK_CHI_IOTA_EN
    if (s1_row == 3'd0)
      s1_entry.a[0] = s1_entry.a[0] ^ s1_rc;
`endif
  end

`ifndef KECCAK_CHI_IOTA_EN
  logic unused_s1_rc;
  assign unused_s1_rc = s1_rc;
`endif

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      s1_valid <= 1'b0;
      s1_row   <= '0;
      s1_rc    <= 1'b0;
      row_cnt  <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else if (clr_i) begin
      s1_valid <= 1'b0;
      row_cnt  <= '0;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      assert (!(push && count == CW'(FIFO_DEPTH)));
      s1_valid <= accept;
      if (accept) begin
        s1_row  <= row_cnt;
        s1_rc   <= rc_i;
        row_cnt <= (row_cnt == 3'd4) ? 3'd0 : row_cnt + 3'd1;
      end
      if (push) begin
        mem[wr_ptr] <= s1_entry;
        wr_ptr      <= (wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  // Head fields come straight from storage; gating with the registered valid
  // keeps stale entries (after clear) off the outputs without adding glitches.
  assign head       = mem[rd_ptr];
  assign a_o        = out_valid_o ? head.a : '0;
  assign b_o        = out_valid_o ? head.b : '0;
  assign c_o        = out_valid_o ? head.c : '0;
  assign d_o        = out_valid_o ? head.d : '0;
  assign e_o        = out_valid_o ? head.e : '0;
  assign row_o      = out_valid_o ? head.row : '0;
  assign out_last_o = out_valid_o && (head.row == 3'd4);

endmodule
